lcd_display_ctrl: RTL and testbench
===================================

Name: lcd_display_ctrl

Overview:
- Responder end of the CPU-to-LCD interface (lcd_update/lcd_busy handshake plus payload).
- Receives the CPU's result and mode requests, formats them into two 16-character lines, and drives an HD44780-compatible 16x2 character LCD in 8-bit write-only mode.
- Sits between the mini CPU and the board LCD pins.

Parameters:
- EN_PULSE_CYC, 12, clock cycles lcd_en is held high per byte.
- CMD_WAIT_CYC, 2500, cycles lcd_en is held low after a normal byte (50 us at 50 MHz).
- CLEAR_WAIT_CYC, 100000, cycles lcd_en is held low after byte 0x01 (2 ms).
- POWERUP_WAIT_CYC, 1000000, cycles waited after reset before the first init byte (20 ms).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- lcd_update  in  1  one-cycle request pulse from the CPU.
- lcd_show_splash  in  1  request the splash screen; sampled with lcd_update.
- lcd_force_blank  in  1  request a blank, display-off screen; sampled with lcd_update.
- lcd_opcode  in  3  opcode to show.
- lcd_reg_idx  in  4  destination register index to show.
- lcd_value  in  16  signed two's-complement result to show.
- lcd_busy  out  1  high whenever the block is not in IDLE.
- lcd_data  out  8  LCD data bus.
- lcd_rs  out  1  0 = command, 1 = character.
- lcd_rw  out  1  constant 0.
- lcd_en  out  1  LCD enable strobe.
- lcd_on  out  1  panel power; constant 1.
- lcd_blon  out  1  backlight; constant 0.

Behaviour:
- Reset values:
  - lcd_busy=1; lcd_en=0; lcd_rs=0; lcd_rw=0; lcd_data=0x00; lcd_on=1; lcd_blon=0.
  - FSM in PWRUP; all counters and the capture registers are 0.
- Byte write (shared by all states):
  - 1 setup cycle with lcd_rs and lcd_data valid and lcd_en=0.
  - Then EN_PULSE_CYC cycles with lcd_en=1.
  - Then lcd_en=0 for CMD_WAIT_CYC cycles, or CLEAR_WAIT_CYC cycles if the byte is command 0x01.
  - lcd_rs and lcd_data stay stable across the whole byte.
- FSM states:
  - PWRUP: count POWERUP_WAIT_CYC cycles, then go to INIT.
  - INIT: write commands 0x38, 0x0C, 0x01, 0x06 in that order, then go to IDLE.
  - IDLE: lcd_busy=0. If lcd_update=1, capture all five payload inputs, set lcd_busy=1 on the next edge, and go to CONV. If lcd_update=0, stay.
  - CONV: sign = lcd_value[15]; mag = sign ? -lcd_value : lcd_value, taken as 16-bit unsigned (0x8000 gives 32768). Run a sequential double-dabble, one shift per cycle, for exactly 16 cycles to produce 5 BCD digits. Then go to WRITE.
  - WRITE: sends a byte list selected by the captured mode, then returns to IDLE after the last byte's wait completes.
- Mode priority: force_blank > show_splash > normal.
  - Blank list: command 0x08, then command 0x01 (2 bytes).
  - Splash and normal list (35 bytes): command 0x0C, command 0x80, 16 line-1 characters, command 0xC0, 16 line-2 characters.
- Line contents:
  - Splash line 1: "   MINI-CPU     ".
  - Splash line 2: "     READY      ".
  - Normal line 1: cols 0-3 hold the mnemonic, col 4 a space, col 5 '[', cols 6-9 reg_idx in binary (MSB first, '0'/'1'), col 10 ']', cols 11-15 spaces.
  - Mnemonics by opcode: 000 "LOAD", 001 "ADD ", 010 "ADDI", 011 "SUB ", 100 "SUBI", 101 "MUL ", 110 "CLR ", 111 "DPL ".
  - Normal line 2: col 0 is '-' if sign else '+'; cols 1-5 are the decimal digits (ASCII 0x30+d, leading zeros kept); cols 6-15 are spaces.
- Handshake rules:
  - lcd_update is ignored in every state except IDLE, including the cycle in which the FSM enters IDLE from WRITE.
  - No queueing: only one request is held at a time.
  - Payload inputs are don't-care except in the capture cycle.
- Reset mid-operation: asserting rst in any state forces the reset values immediately, aborts any in-progress byte, and restarts from PWRUP (full init again).

Test Plan (params EN_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=8, POWERUP_WAIT_CYC=20):
1. Release rst -> lcd_busy=1 throughout; after 20 cycles, rs=0 bytes 0x38, 0x0C, 0x01, 0x06; each en-high lasts 2 cycles; en-low lasts 4 cycles (8 after 0x01); lcd_busy falls after the last wait.
2. In IDLE, pulse update with opcode=010, reg=0011, value=0xFFFB -> lcd_busy=1 on the next edge; 35 bytes; line 1 "ADDI [0011]     ", line 2 "-00005          ".
3. Values 0x8000 / 0x7FFF / 0x0000 with opcode=101 -> line 2 begins "-32768" / "+32767" / "+00000"; line 1 begins "MUL ".
4. update with splash=1 -> splash lines exactly as specified; update with splash=1 and force_blank=1 -> only 0x08 then 0x01 are sent; lcd_busy clears 8 cycles after the 0x01 en falls.
5. update pulsed while lcd_busy=1, and in the cycle the FSM enters IDLE -> no bytes are sent and the captured payload is unchanged; a later update in IDLE is accepted.
6. Assert rst during a line-2 character's en-high -> lcd_en=0 and lcd_busy=1 with no clock edge; after release, the 20-cycle wait and the 4-byte init repeat.

Source files
------------

// File: rtl/lcd_display_ctrl.sv
// Formats CPU result/mode requests into two 16-char lines and writes them to an
// HD44780-style 16x2 LCD over an 8-bit write-only bus.
module lcd_display_ctrl #(
  parameter int EN_PULSE_CYC     = 12,
  parameter int CMD_WAIT_CYC     = 2500,
  parameter int CLEAR_WAIT_CYC   = 100000,
  parameter int POWERUP_WAIT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_update,
  input  logic        lcd_show_splash,
  input  logic        lcd_force_blank,
  input  logic [2:0]  lcd_opcode,
  input  logic [3:0]  lcd_reg_idx,
  input  logic [15:0] lcd_value,
  output logic        lcd_busy,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        lcd_blon
);
  typedef enum logic [2:0] {PWRUP, INIT, IDLE, CONV, WRITE} state_t;
  typedef enum logic [1:0] {B_SETUP, B_EN, B_WAIT} phase_t;

  localparam logic [127:0] SPLASH1 = "   MINI-CPU     ";
  localparam logic [127:0] SPLASH2 = "     READY      ";

  state_t      state;
  phase_t      ph;
  logic [31:0] cnt;
  logic [5:0]  idx;
  logic        cap_blank, cap_splash;
  logic [2:0]  cap_op;
  logic [3:0]  cap_reg;
  logic [15:0] cap_val;
  logic [19:0] bcd;

  logic [15:0] mag;
  logic [18:0] bcd_adj;
  logic [31:0] wait_end;
  logic [5:0]  last_idx, lk_i;
  logic        lk_init;
  logic [3:0]  col;
  logic [31:0] mnem;
  logic [7:0]  l1_char, l2_char;
  logic [8:0]  lk_byte;

  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b0;

  assign mag = cap_val[15] ? -cap_val : cap_val;

  // Top digit never exceeds 1 before the final shift (max 32768), so it is never adjusted.
  always_comb begin
    bcd_adj = bcd[18:0];
    for (int d = 0; d < 4; d++)
      if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
  end

  assign wait_end = (!lcd_rs && lcd_data == 8'h01) ? 32'(CLEAR_WAIT_CYC - 1) : 32'(CMD_WAIT_CYC - 1);
  assign last_idx = (state == INIT) ? 6'd3 : (cap_blank ? 6'd1 : 6'd34);
  assign lk_init  = (state == PWRUP) || (state == INIT);
  // Lookup points at the byte to be loaded next: first of a list, or the one after idx.
  assign lk_i     = (state == PWRUP || state == CONV) ? 6'd0 : idx + 6'd1;
  assign col      = (lk_i < 6'd19) ? 4'(lk_i - 6'd2) : 4'(lk_i - 6'd19);

  always_comb begin
    case (cap_op)
      3'd0:    mnem = "LOAD";
      3'd1:    mnem = "ADD ";
      3'd2:    mnem = "ADDI";
      3'd3:    mnem = "SUB ";
      3'd4:    mnem = "SUBI";
      3'd5:    mnem = "MUL ";
      3'd6:    mnem = "CLR ";
      default: mnem = "DPL ";
    endcase
    l1_char = " ";
    l2_char = " ";
    if (cap_splash) begin
      l1_char = SPLASH1[{~col, 3'b000} +: 8];
      l2_char = SPLASH2[{~col, 3'b000} +: 8];
    end else begin
      case (col)
        4'd0, 4'd1, 4'd2, 4'd3: l1_char = mnem[{~col[1:0], 3'b000} +: 8];
        4'd5:  l1_char = "[";
        4'd6:  l1_char = cap_reg[3] ? "1" : "0";
        4'd7:  l1_char = cap_reg[2] ? "1" : "0";
        4'd8:  l1_char = cap_reg[1] ? "1" : "0";
        4'd9:  l1_char = cap_reg[0] ? "1" : "0";
        4'd10: l1_char = "]";
        default: ;
      endcase
      case (col)
        4'd0: l2_char = cap_val[15] ? "-" : "+";
        4'd1: l2_char = {4'h3, bcd[19:16]};
        4'd2: l2_char = {4'h3, bcd[15:12]};
        4'd3: l2_char = {4'h3, bcd[11:8]};
        4'd4: l2_char = {4'h3, bcd[7:4]};
        4'd5: l2_char = {4'h3, bcd[3:0]};
        default: ;
      endcase
    end
  end

  // {rs, data} of the next byte to send.
  always_comb begin
    lk_byte = 9'h000;
    if (lk_init) begin
      case (lk_i[1:0])
        2'd0: lk_byte = 9'h038;
        2'd1: lk_byte = 9'h00C;
        2'd2: lk_byte = 9'h001;
        default: lk_byte = 9'h006;
      endcase
    end else if (cap_blank)       lk_byte = (lk_i == 6'd0) ? 9'h008 : 9'h001;
    else if (lk_i == 6'd0)        lk_byte = 9'h00C;
    else if (lk_i == 6'd1)        lk_byte = 9'h080;
    else if (lk_i == 6'd18)       lk_byte = 9'h0C0;
    else if (lk_i < 6'd18)        lk_byte = {1'b1, l1_char};
    else                          lk_byte = {1'b1, l2_char};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PWRUP;
      ph         <= B_SETUP;
      cnt        <= '0;
      idx        <= '0;
      cap_blank  <= 1'b0;
      cap_splash <= 1'b0;
      cap_op     <= '0;
      cap_reg    <= '0;
      cap_val    <= '0;
      bcd        <= '0;
      lcd_busy   <= 1'b1;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
    end else begin
      case (state)
        PWRUP:
          if (cnt == 32'(POWERUP_WAIT_CYC - 1)) begin
            state <= INIT;
            cnt   <= '0;
            idx   <= '0;
            ph    <= B_SETUP;
            {lcd_rs, lcd_data} <= lk_byte;
          end else cnt <= cnt + 32'd1;
        IDLE:
          if (lcd_update) begin
            cap_blank  <= lcd_force_blank;
            cap_splash <= lcd_show_splash;
            cap_op     <= lcd_opcode;
            cap_reg    <= lcd_reg_idx;
            cap_val    <= lcd_value;
            bcd        <= '0;
            cnt        <= '0;
            lcd_busy   <= 1'b1;
            state      <= CONV;
          end
        CONV: begin
          bcd <= {bcd_adj, mag[4'd15 - cnt[3:0]]};
          if (cnt == 32'd15) begin
            state <= WRITE;
            cnt   <= '0;
            idx   <= '0;
            ph    <= B_SETUP;
            {lcd_rs, lcd_data} <= lk_byte;
          end else cnt <= cnt + 32'd1;
        end
        default:
          case (ph)
            B_SETUP: begin
              lcd_en <= 1'b1;
              ph     <= B_EN;
              cnt    <= '0;
            end
            B_EN:
              if (cnt == 32'(EN_PULSE_CYC - 1)) begin
                lcd_en <= 1'b0;
                ph     <= B_WAIT;
                cnt    <= '0;
              end else cnt <= cnt + 32'd1;
            default:
              if (cnt == wait_end) begin
                cnt <= '0;
                if (idx == last_idx) begin
                  state    <= IDLE;
                  lcd_busy <= 1'b0;
                end else begin
                  idx <= idx + 6'd1;
                  ph  <= B_SETUP;
                  {lcd_rs, lcd_data} <= lk_byte;
                end
              end else cnt <= cnt + 32'd1;
          endcase
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_display_ctrl.sv
// Randomized bench for lcd_display_ctrl: a per-cycle trace model built from byte
// lists and line strings, plus literal checks on line text and transaction lengths.
module tb_lcd_display_ctrl;
  localparam int EN = 2, CMDW = 4, CLRW = 8, PWR = 20;

  logic        clk = 1'b0, rst;
  logic        lcd_update, lcd_show_splash, lcd_force_blank;
  logic [2:0]  lcd_opcode;
  logic [3:0]  lcd_reg_idx;
  logic [15:0] lcd_value;
  logic        lcd_busy, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
  logic [7:0]  lcd_data;

  lcd_display_ctrl #(.EN_PULSE_CYC(EN), .CMD_WAIT_CYC(CMDW), .CLEAR_WAIT_CYC(CLRW),
                     .POWERUP_WAIT_CYC(PWR)) dut (
    .clk(clk), .rst(rst), .lcd_update(lcd_update), .lcd_show_splash(lcd_show_splash),
    .lcd_force_blank(lcd_force_blank), .lcd_opcode(lcd_opcode), .lcd_reg_idx(lcd_reg_idx),
    .lcd_value(lcd_value), .lcd_busy(lcd_busy), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on), .lcd_blon(lcd_blon));

  always #5 clk = ~clk;

  typedef struct packed { logic busy; logic en; logic rs; logic [7:0] data; int bi; } ent_t;
  ent_t       q[$];
  ent_t       cur;
  logic [8:0] got[$];
  int         tests = 0, fails = 0;
  string      mn[8] = '{"LOAD", "ADD ", "ADDI", "SUB ", "SUBI", "MUL ", "CLR ", "DPL "};

  function automatic ent_t mk(logic b, logic e, logic r, logic [7:0] d, int bi);
    return '{b, e, r, d, bi};
  endfunction

  // Expected outputs for the cycle following each rising edge.
  always @(posedge clk) begin
    #1;
    tests++;
    if ({lcd_busy, lcd_en, lcd_rs, lcd_data, lcd_rw, lcd_on, lcd_blon} !==
        {cur.busy, cur.en, cur.rs, cur.data, 3'b010}) begin
      fails++;
      $display("FAIL cycle t=%0t busy/en/rs/data/rw/on/blon got %b %b %b %h %b %b %b want %b %b %b %h 0 1 0",
               $time, lcd_busy, lcd_en, lcd_rs, lcd_data, lcd_rw, lcd_on, lcd_blon,
               cur.busy, cur.en, cur.rs, cur.data);
    end
  end

  always @(posedge lcd_en) got.push_back({lcd_rs, lcd_data});

  task automatic push_byte(input logic rs, input logic [7:0] d, input int bi);
    q.push_back(mk(1'b1, 1'b0, rs, d, bi));
    repeat (EN) q.push_back(mk(1'b1, 1'b1, rs, d, bi));
    repeat ((!rs && d == 8'h01) ? CLRW : CMDW) q.push_back(mk(1'b1, 1'b0, rs, d, bi));
  endtask

  task automatic make_lines(input bit sp, input logic [2:0] op, input logic [3:0] rg,
                            input logic [15:0] v, output string l1, output string l2);
    int sv;
    if (sp) begin
      l1 = "   MINI-CPU     ";
      l2 = "     READY      ";
    end else begin
      sv = int'($signed(v));
      l1 = {mn[op], $sformatf(" [%04b]     ", rg)};
      l2 = $sformatf("%s%05d          ", (sv < 0) ? "-" : "+", (sv < 0) ? -sv : sv);
    end
  endtask

  task automatic push_request(input bit sp, input bit bl, input logic [2:0] op,
                              input logic [3:0] rg, input logic [15:0] v);
    string l1, l2;
    repeat (16) q.push_back(mk(1'b1, 1'b0, cur.rs, cur.data, -1));
    if (bl) begin
      push_byte(1'b0, 8'h08, 0);
      push_byte(1'b0, 8'h01, 1);
    end else begin
      make_lines(sp, op, rg, v, l1, l2);
      push_byte(1'b0, 8'h0C, 0);
      push_byte(1'b0, 8'h80, 1);
      for (int i = 0; i < 16; i++) push_byte(1'b1, l1[i], 2 + i);
      push_byte(1'b0, 8'hC0, 18);
      for (int i = 0; i < 16; i++) push_byte(1'b1, l2[i], 19 + i);
    end
  endtask

  task automatic step(input bit upd, input bit sp, input bit bl, input logic [2:0] op,
                      input logic [3:0] rg, input logic [15:0] v);
    @(negedge clk);
    lcd_update = upd; lcd_show_splash = sp; lcd_force_blank = bl;
    lcd_opcode = op; lcd_reg_idx = rg; lcd_value = v;
    if (upd && !cur.busy) push_request(sp, bl, op, rg, v);
    if (q.size() > 0) cur = q.pop_front();
    else cur = mk(1'b0, 1'b0, cur.rs, cur.data, -1);
  endtask

  // Random payload; update is only pulsed while the model says the block is busy.
  task automatic idle_step(input bit spur);
    step(spur && cur.busy, 1'($urandom), 1'($urandom), 3'($urandom), 4'($urandom), 16'($urandom));
  endtask

  task automatic wait_idle(input bit spur, output int n);
    n = 0;
    do begin
      idle_step(spur && (q.size() == 0 || $urandom_range(0, 7) == 0));
      n++;
    end while (lcd_busy && n < 3000);
    if (lcd_busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout busy still %b after %0d cycles", lcd_busy, n);
    end
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b1; lcd_update = 1'b0;
    if (chk) begin
      #1;
      tests++;
      if (lcd_en !== 1'b0 || lcd_busy !== 1'b1) begin
        fails++;
        $display("FAIL async_reset en=%b busy=%b want en=0 busy=1", lcd_en, lcd_busy);
      end
    end
    q.delete();
    cur = mk(1'b1, 1'b0, 1'b0, 8'h00, -1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got.delete();
    repeat (PWR - 1) q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, -1));
    push_byte(1'b0, 8'h38, 0); push_byte(1'b0, 8'h0C, 1);
    push_byte(1'b0, 8'h01, 2); push_byte(1'b0, 8'h06, 3);
    cur = q.pop_front();
  endtask

  task automatic request(input bit sp, input bit bl, input logic [2:0] op,
                         input logic [3:0] rg, input logic [15:0] v);
    got.delete();
    step(1'b1, sp, bl, op, rg, v);
    step(cur.busy, 1'($urandom), 1'($urandom), 3'($urandom), 4'($urandom), 16'($urandom));
    tests++;
    if (lcd_busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_update got %b want 1", lcd_busy);
    end
  endtask

  task automatic check_len(input string nm, input int n, input int want);
    tests++;
    if (n != want) begin
      fails++;
      $display("FAIL %s busy cycles got %0d want %0d", nm, n, want);
    end
  endtask

  task automatic check_init(input string nm);
    tests++;
    if (got.size() != 4 || got[0] !== 9'h038 || got[1] !== 9'h00C ||
        got[2] !== 9'h001 || got[3] !== 9'h006) begin
      fails++;
      $display("FAIL %s init bytes got %p want 038 00c 001 006", nm, got);
    end
  endtask

  task automatic check_blank(input string nm);
    tests++;
    if (got.size() != 2 || got[0] !== 9'h008 || got[1] !== 9'h001) begin
      fails++;
      $display("FAIL %s blank bytes got %p want 008 001", nm, got);
    end
  endtask

  task automatic check_txn(input string nm, input string e1, input string e2);
    string s1, s2;
    bit ok;
    s1 = ""; s2 = "";
    tests++;
    if (got.size() != 35) begin
      fails++;
      $display("FAIL %s byte count got %0d want 35", nm, got.size());
      return;
    end
    ok = (got[0] === 9'h00C) && (got[1] === 9'h080) && (got[18] === 9'h0C0);
    for (int i = 0; i < 16; i++) begin
      ok = ok && got[2 + i][8] && got[19 + i][8];
      s1 = {s1, $sformatf("%c", got[2 + i][7:0])};
      s2 = {s2, $sformatf("%c", got[19 + i][7:0])};
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL %s command/rs framing got %p", nm, got); end
    tests++;
    if (s1 != e1) begin fails++; $display("FAIL %s line1 got \"%s\" want \"%s\"", nm, s1, e1); end
    tests++;
    if (s2 != e2) begin fails++; $display("FAIL %s line2 got \"%s\" want \"%s\"", nm, s2, e2); end
  endtask

  initial begin
    int n;
    bit found;
    logic [15:0] vals[3];
    string l1, l2, e2s[3];
    rst = 1'b1; lcd_update = 1'b0; lcd_show_splash = 1'b0; lcd_force_blank = 1'b0;
    lcd_opcode = '0; lcd_reg_idx = '0; lcd_value = '0;
    cur = mk(1'b1, 1'b0, 1'b0, 8'h00, -1);
    repeat (3) @(negedge clk);

    do_reset(1'b0);
    wait_idle(1'b0, n);
    check_len("init", n, 52);
    check_init("init");

    request(1'b0, 1'b0, 3'b010, 4'b0011, 16'hFFFB);
    wait_idle(1'b0, n);
    check_len("addi", n, 261);
    check_txn("addi", "ADDI [0011]     ", "-00005          ");

    vals = '{16'h8000, 16'h7FFF, 16'h0000};
    e2s  = '{"-32768          ", "+32767          ", "+00000          "};
    for (int i = 0; i < 3; i++) begin
      request(1'b0, 1'b0, 3'b101, 4'b0000, vals[i]);
      wait_idle(1'b1, n);
      check_txn($sformatf("mul%0d", i), "MUL  [0000]     ", e2s[i]);
    end

    request(1'b1, 1'b0, 3'($urandom), 4'($urandom), 16'($urandom));
    wait_idle(1'b1, n);
    check_txn("splash", "   MINI-CPU     ", "     READY      ");

    request(1'b1, 1'b1, 3'($urandom), 4'($urandom), 16'($urandom));
    wait_idle(1'b1, n);
    check_len("blank", n, 34);
    check_blank("blank");

    for (int t = 0; t < 12; t++) begin
      bit sp, bl;
      logic [2:0] op;
      logic [3:0] rg;
      logic [15:0] v;
      repeat ($urandom_range(0, 3)) idle_step(1'b0);
      bl = ($urandom_range(0, 5) == 0);
      sp = bl ? 1'($urandom) : ($urandom_range(0, 4) == 0);
      op = 3'($urandom); rg = 4'($urandom);
      case ($urandom_range(0, 5))
        0: v = 16'h8000;
        1: v = 16'hFFFF;
        default: v = 16'($urandom);
      endcase
      request(sp, bl, op, rg, v);
      wait_idle(1'b1, n);
      if (bl) begin
        check_len($sformatf("rnd%0d", t), n, 34);
        check_blank($sformatf("rnd%0d", t));
      end else begin
        make_lines(sp, op, rg, v, l1, l2);
        check_len($sformatf("rnd%0d", t), n, 261);
        check_txn($sformatf("rnd%0d", t), l1, l2);
      end
    end

    request(1'b0, 1'b0, 3'b011, 4'b1010, 16'd1234);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      idle_step(1'b0);
      found = cur.en && cur.bi >= 20;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL reset_point no line-2 enable seen found=%b want 1", found);
    end
    do_reset(1'b1);
    wait_idle(1'b0, n);
    check_len("reinit", n, 52);
    check_init("reinit");

    request(1'b0, 1'b0, 3'b111, 4'b1111, 16'hFFFF);
    wait_idle(1'b1, n);
    check_txn("after_reset", "DPL  [1111]     ", "-00001          ");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
